// File: rtl/com_ai_pkg.sv
// Shared types and constants for the computer volleyball opponent.
package com_ai_pkg;

  typedef enum logic [2:0] {
    HOME     = 3'd0,
    TRACK    = 3'd1,
    JUMP     = 3'd2,
    AIR      = 3'd3,
    COOLDOWN = 3'd4
  } ai_state_e;

  localparam int SIDE_LEFT  = 0;
  localparam int SIDE_RIGHT = 1;
  localparam int POS_W      = 10;
  localparam int DIFF_W     = 11;
  localparam int SCREEN_W   = 640;

  // Zero-extend a screen coordinate into the signed difference domain.
  function automatic logic signed [DIFF_W-1:0] to_diff(input logic [POS_W-1:0] v);
    return $signed({1'b0, v});
  endfunction

  function automatic logic signed [DIFF_W-1:0] abs_diff(input logic signed [DIFF_W-1:0] d);
    return d[DIFF_W-1] ? -d : d;
  endfunction

endpackage

// File: rtl/com_ai_delay_line.sv
// Tick-enabled shift register for ball samples; full rises once DEPTH samples are held.
module com_ai_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tick,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, tick};
      assign dout = din;
      assign full = 1'b1;
    end else begin : g_shift
      localparam int CW = $clog2(DEPTH + 1);
      logic [W-1:0]  sr [DEPTH];
      logic [CW-1:0] fill;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) sr[i] <= '0;
          fill <= '0;
        end else if (tick) begin
          sr[0] <= din;
          for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
          if (fill != CW'(DEPTH)) fill <= fill + CW'(1);
        end
      end

      assign dout = sr[DEPTH-1];
      assign full = (fill == CW'(DEPTH));
    end
  endgenerate

endmodule

// File: rtl/com_player_ai.sv
// Computer volleyball opponent: delayed ball tracking, timed jump/smash, post-landing cooldown.
// Optional COM_AI_PREDICT_EN aims at a velocity-extrapolated ball x clamped to the own half.
module com_player_ai
  import com_ai_pkg::ai_state_e, com_ai_pkg::HOME, com_ai_pkg::TRACK, com_ai_pkg::JUMP,
         com_ai_pkg::AIR, com_ai_pkg::SIDE_LEFT, com_ai_pkg::POS_W, com_ai_pkg::DIFF_W,
         com_ai_pkg::to_diff, com_ai_pkg::abs_diff;
#(
  parameter int SIDE        = 0,
  parameter int HOME_X      = 60,
  parameter int NET_X       = 320,
  parameter int GROUND_Y    = 315,
  parameter int TOLERANCE   = 5,
  parameter int JUMP_X      = 40,
  parameter int JUMP_Y      = 280,
  parameter int SMASH_X     = 50,
  parameter int JUMP_HOLD   = 4,
  parameter int COOLDOWN    = 8,
  parameter int REACT_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] my_pos_x,
  input  logic [9:0] my_pos_y,
  output logic       op_move_left,
  output logic       op_move_right,
  output logic       op_jump,
  output logic       op_smash,
  output logic [2:0] ai_state
);

  localparam int CNT_MAX = (JUMP_HOLD > COOLDOWN) ? JUMP_HOLD : COOLDOWN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1) + 1;
  localparam logic [CNT_W-1:0] HOLD_C  = CNT_W'(JUMP_HOLD);
  localparam logic [CNT_W-1:0] COOL_C  = CNT_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic signed [DIFF_W-1:0] NET_S    = DIFF_W'(NET_X);
  localparam logic signed [DIFF_W-1:0] HOME_S   = DIFF_W'(HOME_X);
  localparam logic signed [DIFF_W-1:0] GROUND_S = DIFF_W'(GROUND_Y);
  localparam logic signed [DIFF_W-1:0] TOL_S    = DIFF_W'(TOLERANCE);
  localparam logic signed [DIFF_W-1:0] NTOL_S   = DIFF_W'(-TOLERANCE);
  localparam logic signed [DIFF_W-1:0] JX_S     = DIFF_W'(JUMP_X);
  localparam logic signed [DIFF_W-1:0] JY_S     = DIFF_W'(JUMP_Y);
  localparam logic signed [DIFF_W-1:0] SX_S     = DIFF_W'(SMASH_X);
  localparam logic signed [DIFF_W-1:0] DY_LO_S  = DIFF_W'(-80);
  localparam logic signed [DIFF_W-1:0] DY_HI_S  = DIFF_W'(40);

  logic [2*POS_W-1:0] smp;
  logic               smp_full;

  com_ai_delay_line #(
    .DEPTH (REACT_DELAY),
    .W     (2*POS_W)
  ) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick),
    .din   ({ball_x, ball_y}),
    .dout  (smp),
    .full  (smp_full)
  );

  logic signed [DIFF_W-1:0] bx, by, px, py;
  logic signed [DIFF_W-1:0] dx, adx, dy, target_own, target, mdx;
  logic                     own, grounded, jump_ok, gsmash_ok, asmash_ok;

  assign bx = to_diff(smp[2*POS_W-1:POS_W]);
  assign by = to_diff(smp[POS_W-1:0]);
  assign px = to_diff(my_pos_x);
  assign py = to_diff(my_pos_y);

  assign own      = (SIDE == SIDE_LEFT) ? (bx < NET_S) : (bx >= NET_S);
  assign grounded = (py >= GROUND_S);
  assign dx       = bx - px;
  assign adx      = abs_diff(dx);
  assign dy       = by - py;

  assign jump_ok   = grounded && (adx < JX_S) && (by < JY_S);
  assign gsmash_ok = grounded && (adx < SX_S) && (dy > DY_LO_S) && (dy < DY_HI_S);
  assign asmash_ok = (adx < SX_S) && (dy <= 0);

`ifdef COM_AI_PREDICT_EN
  localparam int PRED_W = DIFF_W + 3;
  localparam logic signed [PRED_W-1:0] PRED_LO =
    PRED_W'((SIDE == SIDE_LEFT) ? 0 : NET_X);
  localparam logic signed [PRED_W-1:0] PRED_HI =
    PRED_W'((SIDE == SIDE_LEFT) ? (NET_X - 1) : (com_ai_pkg::SCREEN_W - 1));

  function automatic logic signed [DIFF_W-1:0] sat_target(input logic signed [PRED_W-1:0] v);
    logic signed [PRED_W-1:0] c;
    c = v;
    if (v < PRED_LO) c = PRED_LO;
    if (v > PRED_HI) c = PRED_HI;
    return c[DIFF_W-1:0];
  endfunction

  logic signed [DIFF_W-1:0] prev_bx, vx;
  logic signed [PRED_W-1:0] pred_raw;
  logic                     prev_vld;

  // First valid sample has no history, so it is treated as stationary.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prev_bx  <= '0;
      prev_vld <= 1'b0;
    end else if (tick && smp_full) begin
      prev_bx  <= bx;
      prev_vld <= 1'b1;
    end
  end

  assign vx         = prev_vld ? (bx - prev_bx) : '0;
  assign pred_raw   = {{3{bx[DIFF_W-1]}}, bx} + {vx[DIFF_W-1], vx, 2'b00};
  assign target_own = sat_target(pred_raw);
`else
  assign target_own = bx;
`endif

  assign target = own ? target_own : HOME_S;
  assign mdx    = target - px;

  ai_state_e        state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             left_nx, right_nx, jump_nx, smash_nx;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    jump_nx  = 1'b0;
    smash_nx = 1'b0;
    left_nx  = smp_full && (mdx < NTOL_S);
    right_nx = smp_full && (mdx > TOL_S);
    if (!smp_full) begin
      state_nx = HOME;
      cnt_nx   = '0;
    end else begin
      unique case (state)
        HOME: begin
          if (own) state_nx = TRACK;
        end
        TRACK: begin
          if (!own) begin
            state_nx = HOME;
          end else if (jump_ok) begin
            state_nx = JUMP;
            cnt_nx   = CNT_ONE;
            jump_nx  = 1'b1;
          end else begin
            smash_nx = gsmash_ok;
          end
        end
        JUMP: begin
          if (cnt >= HOLD_C) begin
            state_nx = AIR;
            cnt_nx   = '0;
          end else begin
            cnt_nx  = cnt + CNT_ONE;
            jump_nx = 1'b1;
          end
        end
        AIR: begin
          if (grounded) begin
            state_nx = com_ai_pkg::COOLDOWN;
            cnt_nx   = CNT_ONE;
          end else begin
            smash_nx = asmash_ok;
          end
        end
        com_ai_pkg::COOLDOWN: begin
          if (cnt >= COOL_C) begin
            state_nx = own ? TRACK : HOME;
            cnt_nx   = '0;
          end else begin
            cnt_nx = cnt + CNT_ONE;
          end
        end
        default: begin
          state_nx = HOME;
          cnt_nx   = '0;
        end
      endcase
    end
  end

  // Registered decision stage; holds between ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HOME;
      cnt           <= '0;
      op_move_left  <= 1'b0;
      op_move_right <= 1'b0;
      op_jump       <= 1'b0;
      op_smash      <= 1'b0;
    end else if (tick) begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      op_move_left  <= left_nx;
      op_move_right <= right_nx;
      op_jump       <= jump_nx;
      op_smash      <= smash_nx;
    end
  end

  assign ai_state = state;

endmodule

// File: tb/tb_com_player_ai.sv
// Randomised bench for com_player_ai: both sides of the net against a behavioural model.
module tb_com_player_ai;

  localparam int RD     = 3;
  localparam int HOLD   = 4;
  localparam int CD     = 8;
  localparam int NET    = 320;
  localparam int HOME_L = 60;
  localparam int HOME_R = 580;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [9:0] ball_x = '0, ball_y = '0, my_pos_x = '0, my_pos_y = '0;
  logic       l_left, l_right, l_jump, l_smash;
  logic       r_left, r_right, r_jump, r_smash;
  logic [2:0] l_state, r_state;

  always #5 clk = ~clk;

  com_player_ai #(.SIDE(0), .HOME_X(HOME_L)) dut_l (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ball_x(ball_x), .ball_y(ball_y), .my_pos_x(my_pos_x), .my_pos_y(my_pos_y),
    .op_move_left(l_left), .op_move_right(l_right), .op_jump(l_jump),
    .op_smash(l_smash), .ai_state(l_state)
  );

  com_player_ai #(.SIDE(1), .HOME_X(HOME_R)) dut_r (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .ball_x(ball_x), .ball_y(ball_y), .my_pos_x(my_pos_x), .my_pos_y(my_pos_y),
    .op_move_left(r_left), .op_move_right(r_right), .op_jump(r_jump),
    .op_smash(r_smash), .ai_state(r_state)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: ball history queue plus a phase and a remaining-ticks count per side.
  int         hist_x[$];
  int         hist_y[$];
  int         m_phase[2];
  int         m_remain[2];
  logic [6:0] m_out[2];
`ifdef COM_AI_PREDICT_EN
  bit m_prev_vld;
  int m_prev;
`endif

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

  task automatic model_reset();
    hist_x.delete();
    hist_y.delete();
    for (int s = 0; s < 2; s++) begin
      m_phase[s] = 0;
      m_remain[s] = 0;
      m_out[s] = '0;
    end
`ifdef COM_AI_PREDICT_EN
    m_prev_vld = 0;
    m_prev = 0;
`endif
  endtask

  task automatic side_step(input int s, input int bx, input int by, input int px, input int py);
    bit own, gnd, el, er, ej, es;
    int tgt, adx;
    own = (s == 0) ? (bx < NET) : (bx >= NET);
    gnd = (py >= 315);
    adx = iabs(bx - px);
`ifdef COM_AI_PREDICT_EN
    tgt = bx + 4 * (m_prev_vld ? (bx - m_prev) : 0);
    tgt = (s == 0) ? clampi(tgt, 0, NET - 1) : clampi(tgt, NET, 639);
`else
    tgt = bx;
`endif
    if (!own) tgt = (s == 0) ? HOME_L : HOME_R;
    er = (tgt > px + 5);
    el = (tgt < px - 5);
    ej = 0;
    es = 0;
    case (m_phase[s])
      0: if (own) m_phase[s] = 1;
      1: begin
        if (!own) m_phase[s] = 0;
        else if (gnd && adx < 40 && by < 280) begin
          m_phase[s] = 2;
          m_remain[s] = HOLD - 1;
          ej = 1;
        end else es = gnd && adx < 50 && by > py - 80 && by < py + 40;
      end
      2: begin
        if (m_remain[s] == 0) m_phase[s] = 3;
        else begin
          m_remain[s]--;
          ej = 1;
        end
      end
      3: begin
        if (gnd) begin
          m_phase[s] = 4;
          m_remain[s] = CD - 1;
        end else es = (adx < 50) && (by <= py);
      end
      default: begin
        if (m_remain[s] == 0) m_phase[s] = own ? 1 : 0;
        else m_remain[s]--;
      end
    endcase
    m_out[s] = {3'(m_phase[s]), el, er, ej, es};
  endtask

  task automatic model_tick(input int nx, input int ny, input int px, input int py);
    if (hist_x.size() >= RD) begin
      side_step(0, hist_x[0], hist_y[0], px, py);
      side_step(1, hist_x[0], hist_y[0], px, py);
`ifdef COM_AI_PREDICT_EN
      m_prev = hist_x[0];
      m_prev_vld = 1;
`endif
    end else begin
      for (int s = 0; s < 2; s++) begin
        m_phase[s] = 0;
        m_remain[s] = 0;
        m_out[s] = '0;
      end
    end
    hist_x.push_back(nx);
    hist_y.push_back(ny);
    if (hist_x.size() > RD) begin
      void'(hist_x.pop_front());
      void'(hist_y.pop_front());
    end
  endtask

  task automatic do_tick(input int bx, input int by, input int px, input int py);
    int gap;
    @(negedge clk);
    ball_x = 10'(bx);
    ball_y = 10'(by);
    my_pos_x = 10'(px);
    my_pos_y = 10'(py);
    tick = 1'b1;
    model_tick(bx, by, px, py);
    @(negedge clk);
    tick = 1'b0;
    check("tick_l", {l_state, l_left, l_right, l_jump, l_smash}, m_out[0]);
    check("tick_r", {r_state, r_left, r_right, r_jump, r_smash}, m_out[1]);
    gap = $urandom_range(0, 2);
    for (int g = 0; g < gap; g++) begin
      ball_x = 10'($urandom_range(0, 639));
      ball_y = 10'($urandom_range(0, 479));
      my_pos_x = 10'($urandom_range(0, 639));
      my_pos_y = 10'($urandom_range(0, 479));
      @(negedge clk);
      check("hold_l", {l_state, l_left, l_right, l_jump, l_smash}, m_out[0]);
      check("hold_r", {r_state, r_left, r_right, r_jump, r_smash}, m_out[1]);
    end
  endtask

  task automatic do_reset(input int cycles, input logic tk);
    @(negedge clk);
    rst_n = 1'b0;
    tick = tk;
    repeat (cycles) @(negedge clk);
    check("rst_l", {l_state, l_left, l_right, l_jump, l_smash}, 0);
    check("rst_r", {r_state, r_left, r_right, r_jump, r_smash}, 0);
    rst_n = 1'b1;
    tick = 1'b0;
    model_reset();
  endtask

  initial begin
    int n, jl, ncd, nj;
    int bx, by, px, py, run;

    model_reset();
    do_reset(2, 1'b1);

    for (int k = 1; k <= 6; k++) begin
      do_tick(100, 200, 60, 320);
      if (k == 3) check("fill_zero", {l_state, l_left, l_right, l_jump, l_smash}, 0);
      if (k == 4) begin
        check("tick4_state", l_state, 1);
        check("tick4_right", l_right, 1);
      end
    end

    repeat (4) do_tick(200, 300, 60, 320);
    check("track_right", l_right, 1);
    check("track_state", l_state, 1);
    repeat (4) do_tick(63, 300, 60, 320);
    check("deadband_l", l_left, 0);
    check("deadband_r", l_right, 0);

    repeat (4) do_tick(400, 300, 420, 320);
    check("right_track", r_state, 1);
    check("left_home", l_state, 0);

    n = 0;
    while (!l_jump && n < 10) begin
      do_tick(100, 250, 90, 320);
      n++;
    end
    check("jump_seen", l_jump, 1);
    check("jump_state", l_state, 2);
    jl = 0;
    while (l_jump && jl < 20) begin
      jl++;
      do_tick(100, 250, 90, 320);
    end
    check("jump_len", jl, HOLD);
    check("air_state", l_state, 3);

    repeat (4) do_tick(110, 240, 90, 250);
    check("air_smash", l_smash, 1);
    check("air_hold", l_state, 3);

    do_tick(100, 250, 90, 320);
    ncd = 0;
    nj = 0;
    while (l_state == 3'd4 && ncd < 20) begin
      ncd++;
      nj += int'(l_jump);
      do_tick(100, 250, 90, 320);
    end
    check("cool_len", ncd, CD);
    check("cool_nojump", nj, 0);
    check("cool_exit", l_state, 1);

    n = 0;
    while (!l_jump && n < 10) begin
      do_tick(100, 250, 90, 320);
      n++;
    end
    check("rejump_seen", l_jump, 1);
    do_reset(1, 1'b0);

    repeat (5) do_tick(0, 300, 2, 320);
    check("edge_left", l_left, 0);
    check("edge_right", l_right, 0);
    do_tick(0, 300, 6, 320);
    check("edge_left6", l_left, 1);

`ifdef COM_AI_PREDICT_EN
    do_reset(1, 1'b0);
    repeat (4) do_tick(100, 300, 130, 320);
    repeat (4) do_tick(110, 300, 130, 320);
    check("predict_right", l_right, 1);
`endif

    for (int i = 0; i < 70; i++) begin
      bx = $urandom_range(0, 639);
      by = $urandom_range(150, 350);
      if ($urandom_range(0, 1) == 1) px = clampi(bx + $urandom_range(0, 120) - 60, 0, 639);
      else px = $urandom_range(0, 639);
      py = ($urandom_range(0, 1) == 1) ? 320 : $urandom_range(200, 330);
      run = $urandom_range(1, 8);
      for (int k = 0; k < run; k++) begin
        if ($urandom_range(0, 3) == 0) py = $urandom_range(200, 330);
        do_tick(bx, by, px, py);
      end
      if ($urandom_range(0, 19) == 0) do_reset(1, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
